// File: rtl/lfc_ram_responder.sv
// rtl/lfc_ram_responder.sv - banked fixed-latency backing memory for the lfc memory side
module lfc_ram_responder #(
    parameter  int NUM_BANKS = 4,
    parameter  int LATENCY   = 4,
    parameter  int MEM_WORDS = 1024,
    localparam int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BANKS-1:0]        ram_mem_REN,
    input  logic [NUM_BANKS-1:0]        ram_mem_WEN,
    input  logic [NUM_BANKS-1:0][31:0]  ram_mem_addr,
    input  logic [NUM_BANKS-1:0][31:0]  ram_mem_store,
    output logic [NUM_BANKS-1:0][31:0]  ram_mem_data,
    output logic [NUM_BANKS-1:0]        ram_mem_complete
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam logic [7:0] CNT_INIT = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        state_t            state_q, state_d;
        logic [7:0]        cnt_q, cnt_d;
        logic              is_wr_q, is_wr_d;
        logic [IDX_W-1:0]  idx_q, idx_d;
        logic [31:0]       wdata_q, wdata_d;
        logic [31:0]       rdata_q;
        logic              complete_q;
        logic              entering_done;
        logic [31:0]       mem_q [MEM_WORDS];
        logic              unused_addr;

        // Address bits outside the word index are deliberately ignored (aliasing).
        assign unused_addr = ^ram_mem_addr[b];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            is_wr_d = is_wr_q;
            idx_d   = idx_q;
            wdata_d = wdata_q;
            case (state_q)
                ST_IDLE: begin
                    if (ram_mem_WEN[b] || ram_mem_REN[b]) begin
                        is_wr_d = ram_mem_WEN[b];
                        idx_d   = ram_mem_addr[b][IDX_W+1:2];
                        if (ram_mem_WEN[b]) begin
                            wdata_d = ram_mem_store[b];
                        end
                        if (LATENCY == 1) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // DONE always exits after one cycle, so a next state of DONE means we are entering it.
        assign entering_done = (state_d == ST_DONE);

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_IDLE;
                cnt_q      <= 8'd0;
                is_wr_q    <= 1'b0;
                idx_q      <= '0;
                wdata_q    <= 32'd0;
                rdata_q    <= 32'd0;
                complete_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                is_wr_q    <= is_wr_d;
                idx_q      <= idx_d;
                wdata_q    <= wdata_d;
                complete_q <= entering_done;
                if (entering_done && !is_wr_d) begin
                    rdata_q <= mem_q[idx_d];
                end
            end
        end

        // Storage survives reset; only a write reaching DONE outside reset commits.
        always_ff @(posedge clk) begin
            if (!rst && entering_done && is_wr_d) begin
                mem_q[idx_d] <= wdata_d;
            end
        end

        assign ram_mem_data[b]     = rdata_q;
        assign ram_mem_complete[b] = complete_q;
    end

endmodule

// File: tb/tb_lfc_ram_responder.sv
// tb/tb_lfc_ram_responder.sv - self-checking bench for lfc_ram_responder
module tb_lfc_ram_responder;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       ren = '0;
    logic [3:0]       wen = '0;
    logic [3:0][31:0] addr = '0;
    logic [3:0][31:0] store = '0;
    logic [3:0][31:0] data4, data1;
    logic [3:0]       cmp4, cmp1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfc_ram_responder #(.NUM_BANKS(4), .LATENCY(4), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .ram_mem_REN(ren), .ram_mem_WEN(wen),
        .ram_mem_addr(addr), .ram_mem_store(store),
        .ram_mem_data(data4), .ram_mem_complete(cmp4)
    );

    lfc_ram_responder #(.NUM_BANKS(4), .LATENCY(1), .MEM_WORDS(1024)) dut1 (
        .clk(clk), .rst(rst), .ram_mem_REN(ren), .ram_mem_WEN(wen),
        .ram_mem_addr(addr), .ram_mem_store(store),
        .ram_mem_data(data1), .ram_mem_complete(cmp1)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Model: a request seen while a bank is free completes exactly lat cycles later.
    int          lat [2] = '{4, 1};
    int          free_at [2][4];
    bit          pend [2][4];
    int          cmp_at [2][4];
    bit          op_wr [2][4];
    int          op_idx [2][4];
    logic [31:0] op_wd [2][4];
    logic [31:0] exp_data [2][4];
    bit          known [2][4];
    logic [31:0] mmem [int];
    bit          chk_en = 1'b0;
    int          cyc = 0;
    bit          m_exp_c;
    logic        m_act_c;
    logic [31:0] m_act_d;
    int          m_key;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 4; b++) begin
                m_act_c = (i == 0) ? cmp4[b] : cmp1[b];
                m_act_d = (i == 0) ? data4[b] : data1[b];
                m_exp_c = pend[i][b] && (cmp_at[i][b] == cyc);
                if (m_exp_c) begin
                    pend[i][b] = 1'b0;
                    m_key = i * 1000000 + b * 10000 + op_idx[i][b];
                    if (op_wr[i][b]) begin
                        mmem[m_key] = op_wd[i][b];
                    end else if (mmem.exists(m_key)) begin
                        exp_data[i][b] = mmem[m_key];
                        known[i][b]    = 1'b1;
                    end else begin
                        known[i][b] = 1'b0;
                    end
                end
                if (chk_en) begin
                    chk($sformatf("model_cmp lat%0d b%0d cyc%0d", lat[i], b, cyc),
                        {31'd0, m_act_c}, {31'd0, m_exp_c});
                    if (known[i][b]) begin
                        chk($sformatf("model_data lat%0d b%0d cyc%0d", lat[i], b, cyc),
                            m_act_d, exp_data[i][b]);
                    end
                end
                if (rst) begin
                    pend[i][b]     = 1'b0;
                    exp_data[i][b] = 32'd0;
                    known[i][b]    = 1'b1;
                    free_at[i][b]  = cyc + 1;
                end else if (cyc >= free_at[i][b] && (ren[b] || wen[b])) begin
                    pend[i][b]    = 1'b1;
                    cmp_at[i][b]  = cyc + lat[i];
                    free_at[i][b] = cyc + lat[i] + 1;
                    op_wr[i][b]   = wen[b];
                    op_idx[i][b]  = int'(addr[b][11:2]);
                    op_wd[i][b]   = store[b];
                end
            end
        end
        if (rst) chk_en = 1'b1;
        cyc++;
    end

    logic [5:0]  hist4 [4];
    logic [5:0]  hist1 [4];
    logic [31:0] d3 [4];
    logic [31:0] d4 [4];
    logic [11:0] e_hist;
    logic [7:0]  f_hist;
    logic [31:0] e_d1, e_d2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request for cycles 0..3, drops it from cycle 4, records cycles 0..5.
    task automatic txn(input logic [3:0] r, input logic [3:0] w);
        ren = r;
        wen = w;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                ren = '0;
                wen = '0;
            end
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                hist4[b][k] = cmp4[b];
                hist1[b][k] = cmp1[b];
                if (k == 3) d3[b] = data4[b];
                if (k == 4) d4[b] = data4[b];
            end
            step();
        end
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();
        @(negedge clk);
        chk("idle_cmp_lat4", {28'd0, cmp4}, 32'd0);
        chk("idle_cmp_lat1", {28'd0, cmp1}, 32'd0);
        chk("idle_data_b0", data4[0], 32'd0);
        chk("idle_data_b3", data4[3], 32'd0);
        step();

        addr[0]  = 32'h10;
        store[0] = 32'hDEADBEEF;
        txn(4'b0000, 4'b0001);
        chk("wr_b0_cmp_timing", {26'd0, hist4[0]}, 32'b010000);
        chk("lat1_cmp_timing", {26'd0, hist1[0]}, 32'b001010);
        txn(4'b0001, 4'b0000);
        chk("rd_b0_cmp_timing", {26'd0, hist4[0]}, 32'b010000);
        chk("rd_b0_data", d4[0], 32'hDEADBEEF);

        for (int b = 0; b < 4; b++) begin
            addr[b]  = 32'h40;
            store[b] = 32'h1111_0000 + b;
        end
        txn(4'b0000, 4'b1111);
        txn(4'b1111, 4'b0000);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("all_rd_cmp_b%0d", b), {26'd0, hist4[b]}, 32'b010000);
            chk($sformatf("all_rd_data_b%0d", b), d4[b], 32'h1111_0000 + b);
        end

        addr[2]  = 32'h20;
        store[2] = 32'h5A5A5A5A;
        txn(4'b0100, 4'b0100);
        chk("rw_both_cmp", {26'd0, hist4[2]}, 32'b010000);
        chk("rw_both_data_kept", d4[2], 32'h1111_0002);
        txn(4'b0100, 4'b0000);
        chk("rw_both_readback", d4[2], 32'h5A5A5A5A);

        addr[1]  = 32'h50;
        store[1] = 32'h0BADCAFE;
        txn(4'b0000, 4'b0010);
        addr[1] = 32'h40;
        ren     = 4'b0010;
        e_hist  = '0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) begin
                addr[1]  = 32'h50;
                store[1] = 32'hFFFFFFFF;
            end
            if (k == 9) ren = '0;
            @(negedge clk);
            e_hist[k] = cmp4[1];
            if (k == 4) e_d1 = data4[1];
            if (k == 9) e_d2 = data4[1];
            step();
        end
        chk("hold_cmp_pattern", {20'd0, e_hist}, 32'h210);
        chk("hold_first_data", e_d1, 32'h1111_0001);
        chk("hold_second_data", e_d2, 32'h0BADCAFE);

        addr[3]  = 32'h30;
        store[3] = 32'h0;
        txn(4'b0000, 4'b1000);
        store[3] = 32'hCAFEF00D;
        wen      = 4'b1000;
        f_hist   = '0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                rst = 1'b1;
                wen = '0;
            end
            if (k == 3) rst = 1'b0;
            @(negedge clk);
            f_hist[k] = cmp4[3];
            step();
        end
        chk("rst_drop_no_cmp", {24'd0, f_hist}, 32'd0);
        txn(4'b1000, 4'b0000);
        chk("rst_drop_rd_cmp", {26'd0, hist4[3]}, 32'b010000);
        chk("rst_drop_rd_data", d4[3], 32'h0);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
